getir_tamponlu: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue, sitting between the L1 instruction cache and the decode/register-read stage (Coz Yazmacoku). Unlike the single-register `getir`, it keeps fetching into a `DERINLIK`-entry queue while decode is stalled. It handles execute-stage redirects and DDB flushes. Each instruction is presented to decode with its PC and incremented PC under a valid/stall handshake.

---
 rtl/getir_tamponlu.sv | 143 ++++++++++++++
 tb/tb_getir_tamponlu.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/getir_tamponlu.sv
// getir_tamponlu
// Instruction-fetch stage with a prefetch queue between the L1 instruction
// cache and the decode stage. It keeps fetching into a DERINLIK-entry
// circular queue while decode is stalled. It also handles execute-stage
// redirects and decode-side flushes.
//
// Parameters
//   DERINLIK       queue depth (power of two, >= 2)
//   BASLANGIC_PS   reset PC in bytes (bits [1:0] zero)
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   ddb_durdur_i              decode stall: hold the queue head
//   ddb_bosalt_i              flush: empty the queue, keep the fetch PC
//   ddb_hazir_o               instruction available (same as cyo_gecerli_o)
//   ddb_yanlis_tahmin_o       one-cycle pulse after an accepted redirect
//   l1b_istek_o, l1b_adr_o    fetch request and address (PC[31:1])
//   l1b_bekle_i, l1b_deger_i  cache wait and returned instruction word
//   yrt_atlanan_ps_gecerli_i  execute redirect valid
//   yrt_atlanan_ps_i          redirect target PC[31:1]
//   cyo_gecerli_o             queue head valid
//   cyo_buyruk_o              head instruction
//   cyo_ps_o                  head PC
//   cyo_ps_artmis_o           head PC + 4 bytes
module getir_tamponlu #(
  parameter int          DERINLIK     = 4,
  parameter logic [31:0] BASLANGIC_PS = 32'h4000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ddb_durdur_i,
  input  logic        ddb_bosalt_i,
  output logic        ddb_hazir_o,
  output logic        ddb_yanlis_tahmin_o,
  output logic        l1b_istek_o,
  output logic [31:1] l1b_adr_o,
  input  logic        l1b_bekle_i,
  input  logic [31:0] l1b_deger_i,
  input  logic        yrt_atlanan_ps_gecerli_i,
  input  logic [31:1] yrt_atlanan_ps_i,
  output logic        cyo_gecerli_o,
  output logic [31:0] cyo_buyruk_o,
  output logic [31:1] cyo_ps_o,
  output logic [31:1] cyo_ps_artmis_o
);

  localparam int              AW   = $clog2(DERINLIK);
  localparam int              CW   = AW + 1;
  localparam logic [CW-1:0]   DOLU = CW'(DERINLIK);
  localparam logic [31:0]     NOP  = 32'h0000_0013;

  logic [31:1]   ps;
  logic [31:0]   buyruk_q [DERINLIK];
  logic [31:1]   ps_q     [DERINLIK];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          yanlis_tahmin;

  logic          bos_degil;
  logic          dolu;
  logic          pop_istegi;
  logic          olagan;
  logic          push;
  logic          pop;
  logic [31:1]   hedef;

  // Redirect and flush both suppress any push or pop in their cycle, so
  // "olagan" marks a cycle where the queue behaves as a plain FIFO. A full
  // queue may still fetch when the head leaves in the same cycle.
  always_comb begin
    bos_degil   = (count != '0);
    dolu        = (count == DOLU);
    pop_istegi  = bos_degil && !ddb_durdur_i;
    olagan      = !rst_i && !yrt_atlanan_ps_gecerli_i && !ddb_bosalt_i;
    l1b_istek_o = olagan && (!dolu || pop_istegi);
    push        = l1b_istek_o && !l1b_bekle_i;
    pop         = olagan && pop_istegi;
    hedef       = yrt_atlanan_ps_i & ~31'h1;
  end

  // Head outputs come straight from the head entry; an empty queue shows a NOP
  // at PC 0 so decode never sees stale data.
  always_comb begin
    cyo_gecerli_o   = bos_degil;
    cyo_buyruk_o    = NOP;
    cyo_ps_o        = '0;
    cyo_ps_artmis_o = '0;
    if (bos_degil) begin
      cyo_buyruk_o    = buyruk_q[rd_ptr];
      cyo_ps_o        = ps_q[rd_ptr];
      cyo_ps_artmis_o = ps_q[rd_ptr] + 31'd2;
    end
  end

  assign ddb_hazir_o         = cyo_gecerli_o;
  assign ddb_yanlis_tahmin_o = yanlis_tahmin;
  assign l1b_adr_o           = ps;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps            <= BASLANGIC_PS[31:1];
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      yanlis_tahmin <= 1'b0;
    end else if (yrt_atlanan_ps_gecerli_i) begin
      ps            <= hedef;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      yanlis_tahmin <= 1'b1;
    end else if (ddb_bosalt_i) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      yanlis_tahmin <= 1'b0;
    end else begin
      yanlis_tahmin <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        ps     <= ps + 31'd2;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Queue storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buyruk_q[wr_ptr] <= l1b_deger_i;
      ps_q[wr_ptr]     <= ps;
    end
  end

endmodule

// File: tb/tb_getir_tamponlu.sv
// Self-checking bench for getir_tamponlu: a fixed vector table from reset,
// directed multi-cycle corner cases, then random stimulus checked against a
// queue-based reference model.
module tb_getir_tamponlu;

  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic        H    = 1'b1;
  localparam logic        L    = 1'b0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ddb_durdur_i = 1'b0;
  logic        ddb_bosalt_i = 1'b0;
  logic        ddb_hazir_o;
  logic        ddb_yanlis_tahmin_o;
  logic        l1b_istek_o;
  logic [31:1] l1b_adr_o;
  logic        l1b_bekle_i = 1'b0;
  logic [31:0] l1b_deger_i = '0;
  logic        yrt_atlanan_ps_gecerli_i = 1'b0;
  logic [31:1] yrt_atlanan_ps_i = '0;
  logic        cyo_gecerli_o;
  logic [31:0] cyo_buyruk_o;
  logic [31:1] cyo_ps_o;
  logic [31:1] cyo_ps_artmis_o;

  getir_tamponlu #(.DERINLIK(D), .BASLANGIC_PS(BASE)) dut (
    .clk_i                    (clk_i),
    .rst_i                    (rst_i),
    .ddb_durdur_i             (ddb_durdur_i),
    .ddb_bosalt_i             (ddb_bosalt_i),
    .ddb_hazir_o              (ddb_hazir_o),
    .ddb_yanlis_tahmin_o      (ddb_yanlis_tahmin_o),
    .l1b_istek_o              (l1b_istek_o),
    .l1b_adr_o                (l1b_adr_o),
    .l1b_bekle_i              (l1b_bekle_i),
    .l1b_deger_i              (l1b_deger_i),
    .yrt_atlanan_ps_gecerli_i (yrt_atlanan_ps_gecerli_i),
    .yrt_atlanan_ps_i         (yrt_atlanan_ps_i),
    .cyo_gecerli_o            (cyo_gecerli_o),
    .cyo_buyruk_o             (cyo_buyruk_o),
    .cyo_ps_o                 (cyo_ps_o),
    .cyo_ps_artmis_o          (cyo_ps_artmis_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: fetch PC, an unbounded-style queue capped at D, pulse flag.
  typedef struct {
    logic [31:0] b;
    logic [30:0] p;
  } ent_t;

  ent_t        mq[$];
  logic [30:0] mps;
  logic        myt;
  bit          model_ok = 0;

  // Outputs captured in the most recent cycle.
  logic        obs_istek, obs_gec, obs_hazir, obs_yt;
  logic [30:0] obs_adr, obs_ps, obs_art;
  logic [31:0] obs_buy;

  typedef struct {
    logic        r, dur, bek, yon;
    logic [30:0] tgt;
    logic        ist;
    logic [30:0] adr;
    logic        gec;
    logic [31:0] buy;
    logic [30:0] hps;
    logic        yt;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic r, input logic dur, input logic bek,
                              input logic yon, input logic [30:0] tgt,
                              input logic ist, input logic [30:0] adr,
                              input logic gec, input logic [31:0] buy,
                              input logic [30:0] hps, input logic yt);
    vec_t v;
    v.r = r; v.dur = dur; v.bek = bek; v.yon = yon; v.tgt = tgt;
    v.ist = ist; v.adr = adr; v.gec = gec; v.buy = buy; v.hps = hps; v.yt = yt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, sample outputs before the next rising edge,
  // compare against the model, then advance the model by that edge.
  task automatic applyStimulus(input logic r, input logic dur, input logic bos,
                               input logic bek, input logic yon,
                               input logic [30:0] tgt, input logic [31:0] deg);
    logic        e_gec, e_ist;
    logic [31:0] e_buy;
    logic [30:0] e_ps, e_art;
    @(negedge clk_i);
    rst_i = r; ddb_durdur_i = dur; ddb_bosalt_i = bos; l1b_bekle_i = bek;
    yrt_atlanan_ps_gecerli_i = yon; yrt_atlanan_ps_i = tgt; l1b_deger_i = deg;
    #1;
    obs_istek = l1b_istek_o; obs_gec = cyo_gecerli_o; obs_hazir = ddb_hazir_o;
    obs_yt = ddb_yanlis_tahmin_o; obs_adr = l1b_adr_o; obs_ps = cyo_ps_o;
    obs_art = cyo_ps_artmis_o; obs_buy = cyo_buyruk_o;

    e_gec = (mq.size() > 0);
    e_buy = 32'h13; e_ps = '0; e_art = '0;
    if (e_gec) begin
      e_buy = mq[0].b; e_ps = mq[0].p; e_art = mq[0].p + 31'd2;
    end
    e_ist = !r && !yon && !bos && (mq.size() < D || (e_gec && !dur));

    if (model_ok) begin
      checkOutput("m_istek", {31'b0, obs_istek}, {31'b0, e_ist});
      checkOutput("m_adr", {1'b0, obs_adr}, {1'b0, mps});
      checkOutput("m_gecerli", {31'b0, obs_gec}, {31'b0, e_gec});
      checkOutput("m_hazir", {31'b0, obs_hazir}, {31'b0, e_gec});
      checkOutput("m_buyruk", obs_buy, e_buy);
      checkOutput("m_ps", {1'b0, obs_ps}, {1'b0, e_ps});
      checkOutput("m_ps_artmis", {1'b0, obs_art}, {1'b0, e_art});
      checkOutput("m_yanlis_tahmin", {31'b0, obs_yt}, {31'b0, myt});
    end

    if (r) begin
      mps = BASE[31:1]; mq.delete(); myt = 1'b0; model_ok = 1;
    end else if (yon) begin
      mq.delete(); mps = {tgt[30:1], 1'b0}; myt = 1'b1;
    end else if (bos) begin
      mq.delete(); myt = 1'b0;
    end else begin
      myt = 1'b0;
      if (e_gec && !dur) void'(mq.pop_front());
      if (e_ist && !bek) begin
        mq.push_back('{b: deg, p: mps});
        mps = mps + 31'd2;
      end
    end
  endtask

  initial begin
    int          n;
    logic [30:0] prev, held;

    tbl[0]  = mk(H, L, L, L, 31'h0, L, 31'h2000_0000, L, 32'h13,  31'h0, L);
    tbl[1]  = mk(L, L, L, L, 31'h0, H, 31'h2000_0000, L, 32'h13,  31'h0, L);
    tbl[2]  = mk(L, L, L, L, 31'h0, H, 31'h2000_0002, H, 32'h101, 31'h2000_0000, L);
    tbl[3]  = mk(L, H, L, L, 31'h0, H, 31'h2000_0004, H, 32'h102, 31'h2000_0002, L);
    tbl[4]  = mk(L, H, L, L, 31'h0, H, 31'h2000_0006, H, 32'h102, 31'h2000_0002, L);
    tbl[5]  = mk(L, H, L, L, 31'h0, H, 31'h2000_0008, H, 32'h102, 31'h2000_0002, L);
    tbl[6]  = mk(L, H, L, L, 31'h0, L, 31'h2000_000A, H, 32'h102, 31'h2000_0002, L);
    tbl[7]  = mk(L, L, L, L, 31'h0, H, 31'h2000_000A, H, 32'h102, 31'h2000_0002, L);
    tbl[8]  = mk(L, L, H, L, 31'h0, H, 31'h2000_000C, H, 32'h103, 31'h2000_0004, L);
    tbl[9]  = mk(L, L, H, L, 31'h0, H, 31'h2000_000C, H, 32'h104, 31'h2000_0006, L);
    tbl[10] = mk(L, L, H, L, 31'h0, H, 31'h2000_000C, H, 32'h105, 31'h2000_0008, L);
    tbl[11] = mk(L, L, H, L, 31'h0, H, 31'h2000_000C, H, 32'h107, 31'h2000_000A, L);
    tbl[12] = mk(L, L, H, L, 31'h0, H, 31'h2000_000C, L, 32'h13,  31'h0, L);
    tbl[13] = mk(L, L, L, H, 31'h7fff_8001, L, 31'h2000_000C, L, 32'h13, 31'h0, L);
    tbl[14] = mk(L, L, L, L, 31'h0, H, 31'h7fff_8000, L, 32'h13,  31'h0, H);
    tbl[15] = mk(L, L, L, L, 31'h0, H, 31'h7fff_8002, H, 32'h10E, 31'h7fff_8000, L);

    // Unchecked reset to bring the design out of its unknown power-up state.
    applyStimulus(H, L, L, L, L, 31'h0, 32'h0);

    $display("[TB] vector table");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].r, tbl[i].dur, L, tbl[i].bek, tbl[i].yon,
                    tbl[i].tgt, 32'h100 + i);
      checkOutput($sformatf("t%0d_istek", i), {31'b0, obs_istek}, {31'b0, tbl[i].ist});
      checkOutput($sformatf("t%0d_adr", i), {1'b0, obs_adr}, {1'b0, tbl[i].adr});
      checkOutput($sformatf("t%0d_gecerli", i), {31'b0, obs_gec}, {31'b0, tbl[i].gec});
      checkOutput($sformatf("t%0d_buyruk", i), obs_buy, tbl[i].buy);
      checkOutput($sformatf("t%0d_ps", i), {1'b0, obs_ps}, {1'b0, tbl[i].hps});
      checkOutput($sformatf("t%0d_artmis", i), {1'b0, obs_art},
                  tbl[i].gec ? {1'b0, tbl[i].hps + 31'd2} : 32'h0);
      checkOutput($sformatf("t%0d_yt", i), {31'b0, obs_yt}, {31'b0, tbl[i].yt});
    end

    $display("[TB] decode stall and full-queue push/pop");
    applyStimulus(L, L, H, L, L, 31'h0, 32'h0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(L, H, L, L, L, 31'h0, $urandom);
      if (obs_istek) n++;
      if (i == 1) held = obs_ps;
      if (i == 7) checkOutput("stall_head_held", {1'b0, obs_ps}, {1'b0, held});
    end
    checkOutput("stall_pushes", n, 4);
    applyStimulus(L, L, L, L, L, 31'h0, $urandom);
    checkOutput("full_pushpop_istek", {31'b0, obs_istek}, 32'h1);
    applyStimulus(L, H, L, L, L, 31'h0, $urandom);
    checkOutput("full_after_pushpop", {31'b0, obs_istek}, 32'h0);
    prev = obs_ps - 31'd2;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(L, L, L, H, L, 31'h0, $urandom);
      checkOutput($sformatf("drain_order%0d", i), {1'b0, obs_ps}, {1'b0, prev + 31'd2});
      prev = obs_ps;
    end
    applyStimulus(L, L, L, H, L, 31'h0, $urandom);
    checkOutput("drained_gecerli", {31'b0, obs_gec}, 32'h0);

    $display("[TB] redirect with half-full queue");
    applyStimulus(L, H, L, L, L, 31'h0, $urandom);
    applyStimulus(L, H, L, L, L, 31'h0, $urandom);
    applyStimulus(L, L, L, L, H, 31'h7fff_8000, $urandom);
    applyStimulus(L, H, L, L, L, 31'h0, $urandom);
    checkOutput("redir_gecerli", {31'b0, obs_gec}, 32'h0);
    checkOutput("redir_adr", {1'b0, obs_adr}, 32'h7fff_8000);
    checkOutput("redir_yt", {31'b0, obs_yt}, 32'h1);
    applyStimulus(L, H, L, L, L, 31'h0, $urandom);
    checkOutput("redir_yt_clear", {31'b0, obs_yt}, 32'h0);

    $display("[TB] redirect together with flush and stall, then flush alone");
    applyStimulus(L, H, H, L, H, 31'h1234_5678, $urandom);
    applyStimulus(L, H, L, L, L, 31'h0, $urandom);
    checkOutput("rf_adr", {1'b0, obs_adr}, 32'h1234_5678);
    checkOutput("rf_yt", {31'b0, obs_yt}, 32'h1);
    checkOutput("rf_gecerli", {31'b0, obs_gec}, 32'h0);
    applyStimulus(L, H, L, L, L, 31'h0, $urandom);
    applyStimulus(L, H, H, L, L, 31'h0, $urandom);
    held = obs_adr;
    applyStimulus(L, H, L, L, L, 31'h0, $urandom);
    checkOutput("flush_ps_kept", {1'b0, obs_adr}, {1'b0, held});
    checkOutput("flush_gecerli", {31'b0, obs_gec}, 32'h0);

    $display("[TB] fetch PC wrap");
    applyStimulus(L, L, L, L, H, 31'h7fff_fffe, $urandom);
    applyStimulus(L, L, L, L, L, 31'h0, $urandom);
    checkOutput("wrap_adr_top", {1'b0, obs_adr}, 32'h7fff_fffe);
    applyStimulus(L, L, L, L, L, 31'h0, $urandom);
    checkOutput("wrap_adr_zero", {1'b0, obs_adr}, 32'h0);
    checkOutput("wrap_artmis", {1'b0, obs_art}, 32'h0);

    $display("[TB] reset with full queue and redirect");
    for (int i = 0; i < 5; i++) applyStimulus(L, H, L, L, L, 31'h0, $urandom);
    applyStimulus(H, H, L, L, H, 31'h1111_0000, $urandom);
    checkOutput("rst_istek", {31'b0, obs_istek}, 32'h0);
    applyStimulus(L, H, L, H, L, 31'h0, $urandom);
    checkOutput("rst_gecerli", {31'b0, obs_gec}, 32'h0);
    checkOutput("rst_adr", {1'b0, obs_adr}, 32'h2000_0000);
    checkOutput("rst_yt", {31'b0, obs_yt}, 32'h0);
    checkOutput("rst_buyruk", obs_buy, 32'h13);

    $display("[TB] random stimulus");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 15) == 0, 31'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
